// File: rtl/reg_ctrl_seq_if.sv
// Control bundle between the instruction source and the datapath sequencer.
// No latency of its own: it carries signals only.
// No backpressure: run is sampled only while the sequencer is idle.
interface reg_ctrl_seq_if #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4
);
    logic                run;
    logic [15:0]         instr;
    logic [NUM_REGS-1:0] reg_en;
    logic                a_en;
    logic                g_en;
    logic [SEL_W-1:0]    bus_sel;
    logic                alu_sub;
    logic                busy;
    logic                done;
    logic                illegal;

    // Instruction source side.
    modport master (
        output run, instr,
        input  reg_en, a_en, g_en, bus_sel, alu_sub, busy, done, illegal
    );

    // Sequencer side.
    modport slave (
        input  run, instr,
        output reg_en, a_en, g_en, bus_sel, alu_sub, busy, done, illegal
    );
endinterface

// File: rtl/reg_ctrl_seq.sv
// Multi-cycle sequencer: latches an instruction and steps register, bus and ALU enables.
// Latency: MV/MVI finish 2 cycles after the run sample, ADD/SUB after 4; outputs are combinational from state/IR.
// Backpressure: run/instr are ignored while busy; a new run is accepted only in T0.
module reg_ctrl_seq #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4
) (
    input  logic          clk,
    input  logic          reset,
    reg_ctrl_seq_if.slave bus
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

    localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(NUM_REGS);
    localparam logic [SEL_W-1:0] SEL_G   = SEL_W'(NUM_REGS + 1);

    state_t        state_q, state_d;
    logic [15:0]   ir_q, ir_d;

    logic [3:0]    opcode;
    logic [3:0]    rx;
    logic [3:0]    ry;
    logic          rx_ok;
    logic          ry_ok;
    logic          legal;
    logic [NUM_REGS-1:0] rx_onehot;

    assign opcode    = ir_q[15:12];
    assign rx        = ir_q[11:8];
    assign ry        = ir_q[7:4];
    assign rx_ok     = ({28'd0, rx} < NUM_REGS);
    assign ry_ok     = ({28'd0, ry} < NUM_REGS);
    assign rx_onehot = NUM_REGS'(1) << rx;

    // Decode legality: MVI does not reference rY, the other three do.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            4'd0, 4'd2, 4'd3: legal = rx_ok && ry_ok;
            4'd1:             legal = rx_ok;
            default:          legal = 1'b0;
        endcase
    end

    // State and instruction register; reset clears both and aborts any instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and step outputs; reset low forces every output to zero in the same cycle.
    always_comb begin
        state_d     = T0;
        ir_d        = ir_q;
        bus.reg_en  = '0;
        bus.a_en    = 1'b0;
        bus.g_en    = 1'b0;
        bus.bus_sel = '0;
        bus.alu_sub = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.illegal = 1'b0;

        if (reset) begin
            case (state_q)
                T0: begin
                    if (bus.run) begin
                        ir_d    = bus.instr;
                        state_d = T1;
                    end else begin
                        state_d = T0;
                    end
                end
                T1: begin
                    bus.busy = 1'b1;
                    if (!legal) begin
                        bus.illegal = 1'b1;
                        bus.done    = 1'b1;
                        state_d     = T0;
                    end else if (opcode == 4'd0) begin
                        bus.bus_sel = SEL_W'(ry);
                        bus.reg_en  = rx_onehot;
                        bus.done    = 1'b1;
                        state_d     = T0;
                    end else if (opcode == 4'd1) begin
                        bus.bus_sel = SEL_DIN;
                        bus.reg_en  = rx_onehot;
                        bus.done    = 1'b1;
                        state_d     = T0;
                    end else begin
                        // ADD/SUB: load operand A from rX.
                        bus.bus_sel = SEL_W'(rx);
                        bus.a_en    = 1'b1;
                        state_d     = T2;
                    end
                end
                T2: begin
                    bus.busy    = 1'b1;
                    bus.bus_sel = SEL_W'(ry);
                    bus.g_en    = 1'b1;
                    bus.alu_sub = (opcode == 4'd3);
                    state_d     = T3;
                end
                T3: begin
                    bus.busy    = 1'b1;
                    bus.bus_sel = SEL_G;
                    bus.reg_en  = rx_onehot;
                    bus.done    = 1'b1;
                    state_d     = T0;
                end
                default: state_d = T0;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_ctrl_seq.sv
// Bench for reg_ctrl_seq: cycle-by-cycle output vectors, then a small datapath model.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// run is driven directly; the sequencer exerts no backpressure beyond busy.
module tb_reg_ctrl_seq;

    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 4;

    logic clk;
    logic reset;

    reg_ctrl_seq_if #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_if ();

    reg_ctrl_seq #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        rst_n;
        logic        run;
        logic [15:0] instr;
        logic [7:0]  reg_en;
        logic        a_en;
        logic        g_en;
        logic [3:0]  sel;
        logic        sub;
        logic        busy;
        logic        done;
        logic        ill;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t v(input logic r, input logic rn, input logic [15:0] ins,
                               input logic [7:0] re, input logic a, input logic g,
                               input logic [3:0] s, input logic sb, input logic bz,
                               input logic dn, input logic il);
        vec_t t;
        t.rst_n = r;  t.run = rn; t.instr = ins; t.reg_en = re; t.a_en = a; t.g_en = g;
        t.sel = s;    t.sub = sb; t.busy = bz;   t.done = dn;   t.ill = il;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Simple datapath model driven by the sequencer outputs.
    logic [15:0] regs [NUM_REGS];
    logic [15:0] a_q, g_q, din, bus_val;

    always_comb begin
        bus_val = 16'h0;
        if (u_if.bus_sel < 4'(NUM_REGS))        bus_val = regs[u_if.bus_sel[2:0]];
        else if (u_if.bus_sel == 4'(NUM_REGS))  bus_val = din;
        else if (u_if.bus_sel == 4'(NUM_REGS+1)) bus_val = g_q;
    end

    always @(posedge clk) begin
        if (u_if.a_en) a_q <= bus_val;
        if (u_if.g_en) g_q <= u_if.alu_sub ? (a_q - bus_val) : (a_q + bus_val);
        for (int i = 0; i < NUM_REGS; i++)
            if (u_if.reg_en[i]) regs[i] <= bus_val;
    end

    // Issue one instruction; returns cycles from run sample to done (0 on timeout).
    task automatic exec(input logic [15:0] ins, input logic [15:0] imm, output int cyc);
        bit seen;
        seen = 0;
        cyc  = 0;
        @(negedge clk);
        u_if.run   = 1'b1;
        u_if.instr = ins;
        din        = imm;
        cyc        = 1;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            u_if.run = 1'b0;
            cyc++;
            #1;
            if (u_if.done) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL exec_timeout: instr 0x%0h no done within 8 cycles", ins);
            cyc = 0;
        end
    endtask

    int cyc;

    initial begin
        reset      = 1'b0;
        u_if.run   = 1'b0;
        u_if.instr = 16'h0;
        din        = 16'h0;
        a_q        = 16'h0;
        g_q        = 16'h0;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'h0;

        //             rst run instr     reg_en  a  g  sel  sub busy done ill
        tbl[0]  = v(0, 1, 16'h1300, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[1]  = v(0, 1, 16'h1300, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[2]  = v(1, 1, 16'h0150, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[3]  = v(1, 0, 16'h0000, 8'h02, 0, 0, 4'd5, 0, 1, 1, 0);
        tbl[4]  = v(1, 1, 16'h1300, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[5]  = v(1, 0, 16'h0000, 8'h08, 0, 0, 4'd8, 0, 1, 1, 0);
        tbl[6]  = v(1, 1, 16'h2230, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[7]  = v(1, 1, 16'h3230, 8'h00, 1, 0, 4'd2, 0, 1, 0, 0);
        tbl[8]  = v(1, 1, 16'h7000, 8'h00, 0, 1, 4'd3, 0, 1, 0, 0);
        tbl[9]  = v(1, 0, 16'h0000, 8'h04, 0, 0, 4'd9, 0, 1, 1, 0);
        tbl[10] = v(1, 1, 16'h3230, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[11] = v(1, 0, 16'h0000, 8'h00, 1, 0, 4'd2, 0, 1, 0, 0);
        tbl[12] = v(1, 0, 16'h0000, 8'h00, 0, 1, 4'd3, 1, 1, 0, 0);
        tbl[13] = v(1, 0, 16'h0000, 8'h04, 0, 0, 4'd9, 0, 1, 1, 0);
        tbl[14] = v(1, 1, 16'h7000, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[15] = v(1, 0, 16'h0000, 8'h00, 0, 0, 4'd0, 0, 1, 1, 1);
        tbl[16] = v(1, 1, 16'h0A10, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[17] = v(1, 0, 16'h0000, 8'h00, 0, 0, 4'd0, 0, 1, 1, 1);
        tbl[18] = v(1, 1, 16'h2230, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[19] = v(1, 0, 16'h0000, 8'h00, 1, 0, 4'd2, 0, 1, 0, 0);
        tbl[20] = v(0, 0, 16'h0000, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[21] = v(1, 0, 16'h0000, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[22] = v(1, 0, 16'h0000, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[23] = v(1, 1, 16'h13F0, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[24] = v(1, 0, 16'h0000, 8'h08, 0, 0, 4'd8, 0, 1, 1, 0);
        tbl[25] = v(1, 1, 16'h0190, 8'h00, 0, 0, 4'd0, 0, 0, 0, 0);
        tbl[26] = v(1, 0, 16'h0000, 8'h00, 0, 0, 4'd0, 0, 1, 1, 1);

        // Cycle-by-cycle vectors: apply after falling edge, compare before rising edge.
        for (int i = 0; i < NV; i++) begin
            logic [15:0] act;
            logic [15:0] exp;
            @(negedge clk);
            reset      = tbl[i].rst_n;
            u_if.run   = tbl[i].run;
            u_if.instr = tbl[i].instr;
            #1;
            act = {u_if.reg_en, u_if.a_en, u_if.g_en, u_if.bus_sel,
                   u_if.alu_sub, u_if.busy, u_if.done, u_if.illegal};
            exp = {tbl[i].reg_en, tbl[i].a_en, tbl[i].g_en, tbl[i].sel,
                   tbl[i].sub, tbl[i].busy, tbl[i].done, tbl[i].ill};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL vec[%0d]: outputs {reg_en,a,g,sel,sub,busy,done,ill}=0x%0h expected 0x%0h",
                         i, act, exp);
            end
        end

        @(negedge clk);
        reset    = 1'b1;
        u_if.run = 1'b0;

        // Datapath sequences: MVI loads, ADD and SUB with timing.
        exec(16'h1300, 16'h00A5, cyc);
        check("mvi_cycles", cyc, 2);
        @(negedge clk);
        check("r3_after_mvi", {16'h0, regs[3]}, 32'h00A5);

        exec(16'h1200, 16'h0007, cyc);
        @(negedge clk);
        exec(16'h1300, 16'h0002, cyc);
        @(negedge clk);
        check("r2_loaded", {16'h0, regs[2]}, 32'h0007);

        exec(16'h2230, 16'hFFFF, cyc);
        check("add_cycles", cyc, 4);
        @(negedge clk);
        check("r2_after_add", {16'h0, regs[2]}, 32'h0009);

        exec(16'h3230, 16'hFFFF, cyc);
        check("sub_cycles", cyc, 4);
        @(negedge clk);
        check("r2_after_sub", {16'h0, regs[2]}, 32'h0007);

        exec(16'h0520, 16'h0000, cyc);
        check("mv_cycles", cyc, 2);
        @(negedge clk);
        check("r5_after_mv", {16'h0, regs[5]}, 32'h0007);

        exec(16'h2220, 16'h0000, cyc);
        @(negedge clk);
        check("r2_double", {16'h0, regs[2]}, 32'h000E);

        exec(16'h3220, 16'h0000, cyc);
        @(negedge clk);
        check("r2_self_sub", {16'h0, regs[2]}, 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
